cam_capture: RTL and testbench
==============================

// Module: cam_capture
// PURPOSE
//  Frame-buffer writer: samples an OV7670-style parallel camera port (pclk/vsync/href/d[7:0]).
//  Assembles 2-byte pixels and decimates 640x480 to c_img_cols x c_img_rows.
//  Writes pixels into the frame buffer that the VGA display path reads.
//  Sits between the camera pins and the write port of the dual-port frame buffer.
// PARAMETERS
//  c_img_cols    80   buffer columns; camera columns = c_img_cols << c_dec_log2
//  c_img_rows    60   buffer rows; camera rows = c_img_rows << c_dec_log2
//  c_img_pxls    c_img_cols*c_img_rows   buffer depth
//  c_nb_img_pxls 13   address width
//  c_dec_log2    3    decimation factor = 2**c_dec_log2 in both axes
//  c_nb_buf      12   buffer word width (RGB444)
// PORTS
//  clk          in   1   system clock; must be >= 4x cam_pclk
//  rst          in   1   synchronous reset, active high
//  rgbmode      in   1   1: RGB444 capture, 0: YUV (luma) capture
//  cam_pclk     in   1   camera pixel clock; async, sampled as data
//  cam_vsync    in   1   camera vsync, high between frames
//  cam_href     in   1   camera line valid
//  cam_data     in   8   camera byte
//  frame_addr   out  c_nb_img_pxls   buffer write address
//  frame_we     out  1   buffer write enable (1-cycle pulse)
//  frame_wdata  out  c_nb_buf   buffer write data
//  frame_done   out  1   1-cycle pulse when a complete frame has been written
// BEHAVIOUR
//  - Reset: one clock, synchronous, active high; frame_addr/frame_we/frame_wdata/frame_done = 0; FSM -> S_IDLE.
//  - Input sampling:
//    - cam_pclk, cam_vsync, cam_href and cam_data each pass through a 2-FF synchronizer; data is delayed equally.
//    - pclk_rise = synced pclk 0->1; all camera events are qualified by pclk_rise.
//  - FSM:
//    - S_IDLE: wait for synced vsync = 1 -> S_VSYNC.
//    - S_VSYNC: on vsync 1->0 -> S_FRAME. On this transition: clear counters, frame_addr <= 0, latch rgbmode into mode_q.
//    - S_FRAME: capture. On vsync 0->1 -> S_VSYNC, and pulse frame_done for 1 cycle iff frame_addr reached c_img_pxls.
//    - A partial frame after reset is never signalled done.
//  - Byte assembly (S_FRAME, href=1, pclk_rise):
//    - byte_ph toggles. Phase 0 stores byte0; phase 1 completes a pixel and increments cam_col (10b).
//    - href 1->0: byte_ph <= 0, cam_col <= 0, cam_row++ (9b). A dangling phase-0 byte is discarded.
//  - Pixel word:
//    - RGB (mode_q=1): {byte0[3:0], byte1[7:0]} (R, G, B).
//    - YUV (mode_q=0): {4'b0, byte1[7:0]}, i.e. Y of UYVY; the display reads bits [7:4].
//  - Decimation and write:
//    - Write only when cam_col[c_dec_log2-1:0]==0 and cam_row[c_dec_log2-1:0]==0.
//    - Also require cam_col < c_img_cols<<c_dec_log2, cam_row < c_img_rows<<c_dec_log2, and frame_addr < c_img_pxls.
//    - frame_we is high exactly 1 clk, 1 clk after the phase-1 pclk_rise, with frame_wdata/frame_addr valid.
//    - frame_addr increments the cycle after the write.
//    - frame_addr saturates at c_img_pxls; no write ever targets an address >= c_img_pxls (no wrap mid-frame).
//    - frame_addr is reset to 0 only at frame start.
//  - Simultaneous events:
//    - A vsync rise in the same cycle as a pixel completion: the pixel is dropped and the FSM transition wins.
//    - An href fall in the same cycle as pclk_rise: the byte is ignored.
//  - rgbmode changes mid-frame take effect at the next frame start.
// CONFIGURATION
//  - CAM_TESTPAT_EN defined:
//    - Adds input testpat (1b), sampled at frame start.
//    - When set, frame_wdata = {buf_col[6:4], 1'b0, buf_row[5:2], buf_col[3:0]}, where buf_col/buf_row are the decimated coordinates.
//    - Camera timing (vsync/href/pclk) still drives writes; only the data is replaced.
//  - CAM_TESTPAT_EN undefined: no testpat port; data always from the camera.
// TESTING
//  - Reset: assert rst 1 clk mid-frame -> outputs 0, no frame_we until the next vsync 1->0, and no frame_done for that frame.
//  - Full RGB frame, 640x480, byte0=8'h0A, byte1=8'hBC:
//    - 4800 frame_we pulses, addr 0..4799, wdata=12'hABC.
//    - frame_done exactly once at the vsync rise.
//  - YUV mode:
//    - rgbmode=0, bytes U=8'h80, Y=8'h5F -> wdata=12'h05F.
//    - Toggling rgbmode mid-frame keeps 12'h05F until the next frame.
//  - Decimation: a single line with col index k carrying byte1=k[7:0] -> writes at k=0,8,16..632 only; addr 0..79.
//  - Oversize frame: 700x500 camera frame -> exactly 4800 writes, no addr >= 4800, frame_done=1.
//  - Truncated line: href drops after byte0 of col 8 -> no write for col 8, next line starts at byte phase 0.

Source files
------------

// File: rtl/cam_capture.sv
// Camera-port frame-buffer writer: assembles 2-byte OV7670-style pixels and writes a decimated image.
// Build option CAM_TESTPAT_EN adds a testpat input that swaps pixel data for a coordinate pattern.
module cam_capture #(
  parameter int c_img_cols    = 80,
  parameter int c_img_rows    = 60,
  parameter int c_img_pxls    = c_img_cols * c_img_rows,
  parameter int c_nb_img_pxls = 13,
  parameter int c_dec_log2    = 3,
  parameter int c_nb_buf      = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     rgbmode,
  input  logic                     cam_pclk,
  input  logic                     cam_vsync,
  input  logic                     cam_href,
  input  logic [7:0]               cam_data,
`ifdef CAM_TESTPAT_EN
  input  logic                     testpat,
`endif
  output logic [c_nb_img_pxls-1:0] frame_addr,
  output logic                     frame_we,
  output logic [c_nb_buf-1:0]      frame_wdata,
  output logic                     frame_done
);

  localparam int c_nb_col = 10;
  localparam int c_nb_row = 9;
  localparam logic [c_nb_col-1:0]      c_cam_cols = c_nb_col'(c_img_cols << c_dec_log2);
  localparam logic [c_nb_row-1:0]      c_cam_rows = c_nb_row'(c_img_rows << c_dec_log2);
  localparam logic [c_nb_img_pxls-1:0] c_pxls     = c_nb_img_pxls'(c_img_pxls);

  typedef enum logic [1:0] {
    S_IDLE,
    S_VSYNC,
    S_FRAME
  } state_t;

  // Camera inputs: two synchronizer stages plus one history stage for edge detection.
  logic [1:0] pclk_sync_q, vsync_sync_q, href_sync_q;
  logic [7:0] data_s1_q, data_s2_q;
  logic       pclk_prev_q, vsync_prev_q, href_prev_q;

  logic pclk_s, vsync_s, href_s;
  logic pclk_rise, vsync_rise, vsync_fall, href_fall;

  state_t                   state_q, state_d;
  logic [c_nb_img_pxls-1:0] frame_addr_q, frame_addr_d, addr_next;
  logic                     we_q, we_d;
  logic [c_nb_buf-1:0]      wdata_q, wdata_d, pix_word;
  logic                     done_q, done_d;
  logic                     byte_ph_q, byte_ph_d;
  logic [3:0]               byte0_q, byte0_d;
  logic [c_nb_col-1:0]      cam_col_q, cam_col_d;
  logic [c_nb_row-1:0]      cam_row_q, cam_row_d;
  logic                     mode_q, mode_d;
  logic                     dec_hit;

`ifdef CAM_TESTPAT_EN
  logic                             testpat_q, testpat_d;
  logic [c_nb_col-c_dec_log2-1:0]   buf_col;
  logic [c_nb_row-c_dec_log2-1:0]   buf_row;
  assign buf_col = cam_col_q[c_nb_col-1:c_dec_log2];
  assign buf_row = cam_row_q[c_nb_row-1:c_dec_log2];
`endif

  // NOTE: every register below uses <= so all flops sample the same pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pclk_sync_q  <= '0;
      vsync_sync_q <= '0;
      href_sync_q  <= '0;
      data_s1_q    <= '0;
      data_s2_q    <= '0;
      pclk_prev_q  <= 1'b0;
      vsync_prev_q <= 1'b0;
      href_prev_q  <= 1'b0;
    end else begin
      pclk_sync_q  <= {pclk_sync_q[0], cam_pclk};
      vsync_sync_q <= {vsync_sync_q[0], cam_vsync};
      href_sync_q  <= {href_sync_q[0], cam_href};
      data_s1_q    <= cam_data;
      data_s2_q    <= data_s1_q;
      pclk_prev_q  <= pclk_sync_q[1];
      vsync_prev_q <= vsync_sync_q[1];
      href_prev_q  <= href_sync_q[1];
    end
  end

  assign pclk_s     = pclk_sync_q[1];
  assign vsync_s    = vsync_sync_q[1];
  assign href_s     = href_sync_q[1];
  assign pclk_rise  = pclk_s & ~pclk_prev_q;
  assign vsync_rise = vsync_s & ~vsync_prev_q;
  assign vsync_fall = ~vsync_s & vsync_prev_q;
  assign href_fall  = ~href_s & href_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      frame_addr_q <= '0;
      we_q         <= 1'b0;
      wdata_q      <= '0;
      done_q       <= 1'b0;
      byte_ph_q    <= 1'b0;
      byte0_q      <= '0;
      cam_col_q    <= '0;
      cam_row_q    <= '0;
      mode_q       <= 1'b0;
`ifdef CAM_TESTPAT_EN
      testpat_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      frame_addr_q <= frame_addr_d;
      we_q         <= we_d;
      wdata_q      <= wdata_d;
      done_q       <= done_d;
      byte_ph_q    <= byte_ph_d;
      byte0_q      <= byte0_d;
      cam_col_q    <= cam_col_d;
      cam_row_q    <= cam_row_d;
      mode_q       <= mode_d;
`ifdef CAM_TESTPAT_EN
      testpat_q    <= testpat_d;
`endif
    end
  end

  // The address advances the cycle after a write and never passes the buffer depth.
  always_comb begin
    addr_next = frame_addr_q;
    if (we_q && (frame_addr_q < c_pxls)) addr_next = frame_addr_q + c_nb_img_pxls'(1);
  end

  assign dec_hit = (cam_col_q[c_dec_log2-1:0] == '0) &&
                   (cam_row_q[c_dec_log2-1:0] == '0) &&
                   (cam_col_q < c_cam_cols) &&
                   (cam_row_q < c_cam_rows) &&
                   (frame_addr_q < c_pxls);

  // YUV capture keeps only the luma byte, which arrives second in UYVY order.
  always_comb begin
    pix_word = mode_q ? c_nb_buf'({byte0_q, data_s2_q}) : c_nb_buf'(data_s2_q);
`ifdef CAM_TESTPAT_EN
    if (testpat_q) pix_word = c_nb_buf'({buf_col[6:4], 1'b0, buf_row[5:2], buf_col[3:0]});
`endif
  end

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d      = state_q;
    frame_addr_d = addr_next;
    we_d         = 1'b0;
    wdata_d      = wdata_q;
    done_d       = 1'b0;
    byte_ph_d    = byte_ph_q;
    byte0_d      = byte0_q;
    cam_col_d    = cam_col_q;
    cam_row_d    = cam_row_q;
    mode_d       = mode_q;
`ifdef CAM_TESTPAT_EN
    testpat_d    = testpat_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (vsync_s) state_d = S_VSYNC;
      end
      S_VSYNC: begin
        if (vsync_fall) begin
          state_d      = S_FRAME;
          frame_addr_d = '0;
          byte_ph_d    = 1'b0;
          cam_col_d    = '0;
          cam_row_d    = '0;
          mode_d       = rgbmode;
`ifdef CAM_TESTPAT_EN
          testpat_d    = testpat;
`endif
        end
      end
      S_FRAME: begin
        if (vsync_rise) begin
          state_d = S_VSYNC;
          done_d  = (addr_next == c_pxls);
        end else if (href_fall) begin
          byte_ph_d = 1'b0;
          cam_col_d = '0;
          if (cam_row_q != '1) cam_row_d = cam_row_q + c_nb_row'(1);
        end else if (href_s && pclk_rise) begin
          if (!byte_ph_q) begin
            byte0_d   = data_s2_q[3:0];
            byte_ph_d = 1'b1;
          end else begin
            byte_ph_d = 1'b0;
            if (cam_col_q != '1) cam_col_d = cam_col_q + c_nb_col'(1);
            if (dec_hit) begin
              we_d    = 1'b1;
              wdata_d = pix_word;
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign frame_addr  = frame_addr_q;
  assign frame_we    = we_q;
  assign frame_wdata = wdata_q;
  assign frame_done  = done_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture on a reduced 10x6 buffer (camera 80x48, decimation 8) with a write-list model.
module tb_cam_capture;

  localparam int P_COLS   = 10;
  localparam int P_ROWS   = 6;
  localparam int P_DEC    = 3;
  localparam int DEC_F    = 8;
  localparam int P_PXLS   = P_COLS * P_ROWS;
  localparam int CAM_COLS = P_COLS * DEC_F;
  localparam int CAM_ROWS = P_ROWS * DEC_F;

  logic        clk = 1'b0;
  logic        rst, rgbmode, cam_pclk, cam_vsync, cam_href;
  logic [7:0]  cam_data;
  logic [12:0] frame_addr;
  logic        frame_we;
  logic [11:0] frame_wdata;
  logic        frame_done;

  typedef struct {
    int          addr;
    logic [11:0] data;
  } wr_t;

  wr_t         exp_q[$];
  int          checks = 0, errors = 0;
  int          wr_count = 0, done_seen = 0, done_exp = 0;
  int          last_addr = -1;
  logic [11:0] last_data = '0;
  bit          m_active = 1'b0, m_mode = 1'b0;
  int          m_addr = 0, m_row = 0;

  cam_capture #(
    .c_img_cols(P_COLS), .c_img_rows(P_ROWS), .c_img_pxls(P_PXLS),
    .c_nb_img_pxls(13), .c_dec_log2(P_DEC), .c_nb_buf(12)
  ) dut (
    .clk(clk), .rst(rst), .rgbmode(rgbmode),
    .cam_pclk(cam_pclk), .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
`ifdef CAM_TESTPAT_EN
    .testpat(1'b0),
`endif
    .frame_addr(frame_addr), .frame_we(frame_we), .frame_wdata(frame_wdata), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write the DUT issues must be the next one the model predicted.
  always @(negedge clk) begin
    if (frame_we) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_we: got write addr %0d data %03h expected no write", frame_addr, frame_wdata);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("we_addr", 32'(frame_addr), 32'(e.addr));
        check("we_data", 32'(frame_wdata), 32'(e.data));
      end
      wr_count++;
      last_addr = int'(frame_addr);
      last_data = frame_wdata;
    end
    if (frame_done) done_seen++;
  end

  task automatic model_pixel(input int k, input logic [7:0] b0, input logic [7:0] b1);
    wr_t e;
    if (m_active && (k % DEC_F) == 0 && (m_row % DEC_F) == 0 &&
        k < CAM_COLS && m_row < CAM_ROWS && m_addr < P_PXLS) begin
      e.addr = m_addr;
      e.data = m_mode ? {b0[3:0], b1} : {4'h0, b1};
      exp_q.push_back(e);
      m_addr++;
    end
  endtask

  task automatic pclk_byte(input logic [7:0] d);
    cam_pclk = 1'b0;
    cam_data = d;
    repeat (2) @(negedge clk);
    cam_pclk = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_line(input int npix, input logic [7:0] b0, input logic [7:0] b1,
                           input bit col_data, input int trunc_at);
    logic [7:0] d1;
    cam_href = 1'b1;
    repeat (2) @(negedge clk);
    for (int k = 0; k < npix; k++) begin
      d1 = col_data ? k[7:0] : b1;
      pclk_byte(b0);
      if (k == trunc_at) break;
      model_pixel(k, b0, d1);
      pclk_byte(d1);
    end
    cam_pclk = 1'b0;
    cam_href = 1'b0;
    repeat (4) @(negedge clk);
    m_row++;
  endtask

  task automatic rows(input int from, input int upto, input int ncols,
                      input logic [7:0] b0, input logic [7:0] b1);
    for (int r = from; r < upto; r++)
      send_line(((r % DEC_F) == 0) ? ncols : 0, b0, b1, 1'b0, -1);
  endtask

  task automatic frame_start(input bit rgb);
    rgbmode   = rgb;
    cam_vsync = 1'b1;
    repeat (8) @(negedge clk);
    cam_vsync = 1'b0;
    repeat (8) @(negedge clk);
    m_active = 1'b1;
    m_mode   = rgb;
    m_addr   = 0;
    m_row    = 0;
  endtask

  task automatic frame_end();
    cam_vsync = 1'b1;
    repeat (8) @(negedge clk);
    if (m_active && m_addr == P_PXLS) done_exp++;
    m_active = 1'b0;
  endtask

  task automatic settle(input string name);
    repeat (8) @(negedge clk);
    check({name, "_pending"}, 32'(exp_q.size()), 32'd0);
    check({name, "_done"}, 32'(done_seen), 32'(done_exp));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    rst = 1'b1; rgbmode = 1'b1; cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = '0;
    repeat (3) @(negedge clk);
    check("rst_addr", 32'(frame_addr), 32'd0);
    check("rst_we", 32'(frame_we), 32'd0);
    check("rst_wdata", 32'(frame_wdata), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Full RGB frame: every decimated pixel is 12'hABC.
    base = wr_count;
    frame_start(1'b1);
    rows(0, CAM_ROWS, CAM_COLS, 8'h0A, 8'hBC);
    frame_end();
    settle("rgb");
    check("rgb_writes", 32'(wr_count - base), 32'd60);
    check("rgb_last_addr", 32'(last_addr), 32'd59);
    check("rgb_last_data", 32'(last_data), 32'hABC);
    check("rgb_done_cnt", 32'(done_seen), 32'd1);

    // YUV frame with rgbmode flipped halfway: data stays luma-only.
    base = wr_count;
    frame_start(1'b0);
    rows(0, CAM_ROWS / 2, CAM_COLS, 8'h80, 8'h5F);
    rgbmode = 1'b1;
    rows(CAM_ROWS / 2, CAM_ROWS, CAM_COLS, 8'h80, 8'h5F);
    frame_end();
    settle("yuv");
    check("yuv_writes", 32'(wr_count - base), 32'd60);
    check("yuv_last_data", 32'(last_data), 32'h05F);
    check("yuv_done_cnt", 32'(done_seen), 32'd2);

    // One line longer than the camera width, byte1 = column index.
    base = wr_count;
    frame_start(1'b1);
    send_line(CAM_COLS + 8, 8'h00, 8'h00, 1'b1, -1);
    frame_end();
    settle("dec");
    check("dec_writes", 32'(wr_count - base), 32'd10);
    check("dec_last_addr", 32'(last_addr), 32'd9);
    check("dec_last_data", 32'(last_data), 32'h048);
    check("dec_done_cnt", 32'(done_seen), 32'd2);

    // Oversize camera frame: extra columns and rows must be ignored.
    base = wr_count;
    frame_start(1'b1);
    rows(0, CAM_ROWS + 8, CAM_COLS + 10, 8'h05, 8'h67);
    frame_end();
    settle("big");
    check("big_writes", 32'(wr_count - base), 32'd60);
    check("big_last_addr", 32'(last_addr), 32'd59);
    check("big_last_data", 32'(last_data), 32'h567);
    check("big_done_cnt", 32'(done_seen), 32'd3);

    // Line truncated after byte0 of column 8; the next decimated line must realign.
    base = wr_count;
    frame_start(1'b1);
    send_line(CAM_COLS, 8'h01, 8'h23, 1'b0, 8);
    rows(1, DEC_F + 1, CAM_COLS, 8'h0A, 8'hBC);
    frame_end();
    settle("trunc");
    check("trunc_writes", 32'(wr_count - base), 32'd11);
    check("trunc_last_addr", 32'(last_addr), 32'd10);
    check("trunc_last_data", 32'(last_data), 32'hABC);

    // Reset mid-frame: no writes and no done for the remainder of the frame.
    base = wr_count;
    frame_start(1'b1);
    send_line(CAM_COLS, 8'h0A, 8'hBC, 1'b0, -1);
    repeat (4) @(negedge clk);
    check("mid_addr_before", 32'(frame_addr), 32'd10);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_addr", 32'(frame_addr), 32'd0);
    check("mid_rst_we", 32'(frame_we), 32'd0);
    check("mid_rst_wdata", 32'(frame_wdata), 32'd0);
    rst = 1'b0;
    m_active = 1'b0;
    rows(1, DEC_F + 1, CAM_COLS, 8'h0A, 8'hBC);
    frame_end();
    settle("mid");
    check("mid_writes", 32'(wr_count - base), 32'd10);
    check("mid_done_cnt", 32'(done_seen), 32'd3);

    // The interrupted frame is followed by a clean one that completes normally.
    base = wr_count;
    frame_start(1'b1);
    rows(0, CAM_ROWS, CAM_COLS, 8'h0C, 8'h3D);
    frame_end();
    settle("post");
    check("post_writes", 32'(wr_count - base), 32'd60);
    check("post_last_data", 32'(last_data), 32'hC3D);
    check("post_done_cnt", 32'(done_seen), 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
